prism_cfg_sequencer: RTL
========================

Name: prism_cfg_sequencer

Overview:
Sequences reconfiguration of the PRISM controller through its debug write port and shares that port between the TinyQV host and an autonomous loader. The host queues {addr,data} configuration words, then issues go. The block asserts PRISM reset, waits for halt, drains the queue into the debug port and re-enables the FSM. It sits between the peripheral register decode and the prism instance.

Parameters:
DEPTH, 8, configuration queue entries (power of 2, at least 2)
HALT_TIMEOUT, 255, cycles to wait for prism_halted before error (8-bit counter)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
host_wr  input  1  host direct debug write request (single-cycle)
host_addr  input  6  host debug address
host_wdata  input  32  host debug data
q_push  input  1  push {q_addr,q_data} into the queue
q_addr  input  6  queued debug address
q_data  input  32  queued debug data
go  input  1  start the sequence (single-cycle pulse)
abort  input  1  abort the sequence and flush the queue
prism_halted  input  1  PRISM halt status
dbg_wr  output  1  debug write strobe to PRISM
dbg_addr  output  6  debug address to PRISM
dbg_wdata  output  32  debug data to PRISM
prism_reset_o  output  1  PRISM debug_reset
prism_enable_o  output  1  PRISM fsm_enable
q_count  output  log2(DEPTH)+1  queue occupancy
q_full  output  1  q_count==DEPTH
busy  output  1  state != IDLE
done_irq  output  1  sticky; set on sequence completion
err  output  1  sticky; set on overflow or halt timeout

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: dbg_wr=0, dbg_addr=0, dbg_wdata=0, prism_reset_o=0, prism_enable_o=0, q_count=0, busy=0, done_irq=0, err=0, state=IDLE, timeout counter=0.
- All dbg_* outputs are registered: a grant in cycle N produces dbg_wr=1 in cycle N+1 with that grant's addr/data. dbg_wr is 0 in any cycle with no grant.
- Arbitration: host_wr always wins and is never stalled. A loader pop is deferred in any cycle where host_wr=1.
- Queue: FIFO with wrap-around pointers.
  - q_push when full: entry dropped, err set.
  - Simultaneous push and pop: q_count unchanged; a push into an empty queue cannot be popped in the same cycle.
- States:
  - IDLE: prism_reset_o/prism_enable_o hold their last values. go -> HALT. go in any other state is ignored.
  - HALT: prism_reset_o=1, prism_enable_o=0. Timeout counter is cleared on entry and increments each cycle.
    - prism_halted=1 -> LOAD.
    - counter reaches HALT_TIMEOUT with prism_halted=0 -> set err, go to IDLE (prism_reset_o stays 1).
  - LOAD: pops one entry per cycle when not pre-empted by host_wr. When q_count==0 (including on entry) -> RELEASE.
  - RELEASE: one cycle. prism_reset_o=0, prism_enable_o stays 0. This lets the last dbg_wr land first. -> RUN.
  - RUN: one cycle. prism_enable_o=1, done_irq set -> IDLE.
- abort has priority over every other event in any state:
  - queue flushed (q_count=0), next state IDLE;
  - prism_reset_o=1, prism_enable_o=0;
  - an in-flight registered dbg_wr still completes the next cycle.
- abort and go in the same cycle: abort wins.
- q_push during LOAD is accepted. Entries pushed before the queue empties are loaded in the same sequence.
- done_irq and err are cleared only by rst (the clear path lives in the register decode via rst-domain logic owned elsewhere). Setting and holding take no priority over each other.
- rst mid-sequence: all state returns to reset values on the next edge. Queue contents are lost.

Test Plan:
- Push 3 entries (06:0x11, 07:0x22, 08:0x33), go, prism_halted=1 two cycles later -> prism_reset_o=1 from cycle 1; dbg_wr pulses for 3 consecutive cycles in FIFO order; then prism_reset_o=0 for one cycle, prism_enable_o=1, done_irq=1, busy=0.
- During LOAD of 4 entries, assert host_wr (addr 0x3F, data 0xDEADBEEF) for 1 cycle -> host write appears on dbg_* the next cycle; loader resumes; all 4 queue entries still delivered in order, 5 strobes total.
- prism_halted held 0 after go -> after exactly 255 HALT cycles: err=1, state IDLE, prism_reset_o=1, zero dbg_wr pulses.
- Push DEPTH+1 entries -> q_full=1 at DEPTH, err=1, q_count=DEPTH; go drains exactly DEPTH writes, and the dropped 9th entry never appears on dbg_*.
- Assert abort after 2 of 5 writes -> at most one further dbg_wr, q_count=0, busy=0, prism_enable_o=0, done_irq=0.
- go with empty queue, prism_halted=1 -> HALT, then LOAD, RELEASE, RUN with no dbg_wr; done_irq=1 four cycles after go.

Source files
------------

// File: rtl/prism_cfg_sequencer.sv
// Reconfiguration sequencer for PRISM: queues {addr,data} debug writes, halts PRISM,
// drains the queue into the shared debug port (host writes pre-empt), then re-enables it.
module prism_cfg_sequencer #(
  parameter int DEPTH        = 8,
  parameter int HALT_TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     host_wr,
  input  logic [5:0]               host_addr,
  input  logic [31:0]              host_wdata,
  input  logic                     q_push,
  input  logic [5:0]               q_addr,
  input  logic [31:0]              q_data,
  input  logic                     go,
  input  logic                     abort,
  input  logic                     prism_halted,
  output logic                     dbg_wr,
  output logic [5:0]               dbg_addr,
  output logic [31:0]              dbg_wdata,
  output logic                     prism_reset_o,
  output logic                     prism_enable_o,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     q_full,
  output logic                     busy,
  output logic                     done_irq,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [7:0]    TMO_LAST = 8'(HALT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HALT    = 3'd1,
    S_LOAD    = 3'd2,
    S_RELEASE = 3'd3,
    S_RUN     = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      tmo_q, tmo_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            dbg_wr_q, dbg_wr_d;
  logic [5:0]      dbg_addr_q, dbg_addr_d;
  logic [31:0]     dbg_wdata_q, dbg_wdata_d;
  logic            rst_out_q, rst_out_d;
  logic            en_q, en_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [37:0]     mem_q [DEPTH];
  logic            push_s, pop_s, q_full_s;

  assign q_full_s = (count_q == DEPTH_C);

  // Next-state, queue bookkeeping and debug-port grant.
  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rst_out_d   = rst_out_q;
    en_d        = en_q;
    done_d      = done_q;
    err_d       = err_q;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    dbg_wr_d    = 1'b0;
    dbg_addr_d  = dbg_addr_q;
    dbg_wdata_d = dbg_wdata_q;

    if (q_push) begin
      if (!q_full_s) push_s = 1'b1;
      else           err_d  = 1'b1;
    end else begin
      push_s = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d   = S_HALT;
          tmo_d     = 8'd0;
          rst_out_d = 1'b1;
          en_d      = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HALT: begin
        if (prism_halted) begin
          state_d = S_LOAD;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_LOAD: begin
        // Queue is checked before popping so the final pop's strobe lands before RELEASE.
        if (count_q == '0) begin
          state_d   = S_RELEASE;
          rst_out_d = 1'b0;
        end else if (!host_wr) begin
          pop_s = 1'b1;
        end else begin
          pop_s = 1'b0;
        end
      end
      S_RELEASE: begin
        state_d = S_RUN;
        en_d    = 1'b1;
        done_d  = 1'b1;
      end
      S_RUN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort) begin
      push_s    = 1'b0;
      pop_s     = 1'b0;
      state_d   = S_IDLE;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      rst_out_d = 1'b1;
      en_d      = 1'b0;
      err_d     = err_q;
      done_d    = done_q;
    end else begin
      wr_ptr_d = push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    if (host_wr) begin
      dbg_wr_d    = 1'b1;
      dbg_addr_d  = host_addr;
      dbg_wdata_d = host_wdata;
    end else if (pop_s) begin
      dbg_wr_d    = 1'b1;
      dbg_addr_d  = mem_q[rd_ptr_q][37:32];
      dbg_wdata_d = mem_q[rd_ptr_q][31:0];
    end else begin
      dbg_wr_d = 1'b0;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tmo_q       <= 8'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dbg_wr_q    <= 1'b0;
      dbg_addr_q  <= 6'd0;
      dbg_wdata_q <= 32'd0;
      rst_out_q   <= 1'b0;
      en_q        <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      dbg_wr_q    <= dbg_wr_d;
      dbg_addr_q  <= dbg_addr_d;
      dbg_wdata_q <= dbg_wdata_d;
      rst_out_q   <= rst_out_d;
      en_q        <= en_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Queue storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {q_addr, q_data};
    end
  end

  assign dbg_wr         = dbg_wr_q;
  assign dbg_addr       = dbg_addr_q;
  assign dbg_wdata      = dbg_wdata_q;
  assign prism_reset_o  = rst_out_q;
  assign prism_enable_o = en_q;
  assign q_count        = count_q;
  assign q_full         = q_full_s;
  assign busy           = (state_q != S_IDLE);
  assign done_irq       = done_q;
  assign err            = err_q;

endmodule
